// File: rtl/regfile_sb.sv
// Integer register file with per-register busy scoreboard, write-to-read bypass
// and a post-reset sweep that loads every entry before the file reports ready.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int INIT_IDX = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                init_done,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic                rsv_valid,
    input  logic [AW-1:0]       rsv_addr,
    output logic                rsv_waw,
    input  logic                flush
);

    typedef enum logic {S_INIT, S_READY} state_t;

    state_t            state_reg, state_next;
    logic [AW-1:0]     cnt_reg, cnt_next;
    logic [NREGS-1:0]  busy_reg, busy_next;
    logic              ready;

    logic [XLEN-1:0]   regs [NREGS];
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [XLEN-1:0]   wr_data;
    logic              wr_zero;
    logic              rsv_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_INIT;
            cnt_reg   <= '0;
            busy_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            busy_reg  <= busy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (state_reg == S_INIT) begin
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == AW'(NREGS - 1)) begin
                state_next = S_READY;
            end
        end
    end

    always_comb begin
        ready     = (state_reg == S_READY);
        init_done = ready;
    end

    assign wr_zero  = (ZERO_REG != 0) && (waddr == '0);
    assign rsv_zero = (ZERO_REG != 0) && (rsv_addr == '0);

    // The sweep owns the single write port until the file is ready.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = waddr;
        wr_data = wdata;
        if (!ready) begin
            wr_en   = 1'b1;
            wr_addr = cnt_reg;
            wr_data = (INIT_IDX != 0) ? XLEN'(cnt_reg) : '0;
        end else begin
            wr_en = we && !wr_zero;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Set after clear so a reservation racing its own writeback keeps the bit.
    always_comb begin
        busy_next = busy_reg;
        if (ready) begin
            if (flush) begin
                busy_next = '0;
            end
            if (we) begin
                busy_next[waddr] = 1'b0;
            end
            if (rsv_valid && !rsv_zero) begin
                busy_next[rsv_addr] = 1'b1;
            end
        end
    end

    assign rsv_waw = ready & rsv_valid & busy_reg[rsv_addr];

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0]   ra;
            logic            hit;
            logic [XLEN-1:0] rd_val;

            assign ra  = raddr[gi*AW +: AW];
            assign hit = we && (waddr == ra);

            always_comb begin
                rd_val = '0;
                if (ready && !((ZERO_REG != 0) && (ra == '0))) begin
                    rd_val = hit ? wdata : regs[ra];
                end
            end

            assign rdata[gi*XLEN +: XLEN] = rd_val;
            assign rbusy[gi]              = ready & busy_reg[ra] & ~hit;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized and directed bench for regfile_sb against an array/flag reference model.
module tb_regfile_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                init_done;
    logic                we = 1'b0;
    logic [AW-1:0]       waddr = '0;
    logic [XLEN-1:0]     wdata = '0;
    logic [NRD*AW-1:0]   raddr = '0;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;
    logic                rsv_valid = 1'b0;
    logic [AW-1:0]       rsv_addr = '0;
    logic                rsv_waw;
    logic                flush = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_busy [NREGS];
    bit              m_ready;
    int              m_edges;

    regfile_sb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_done (init_done),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr     (raddr),
        .rdata     (rdata),
        .rbusy     (rbusy),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rsv_waw   (rsv_waw),
        .flush     (flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ready = 0;
        m_edges = 0;
        for (int i = 0; i < NREGS; i++) m_busy[i] = 0;
    endtask

    function automatic logic [AW-1:0] port_addr(input int k);
        logic [NRD*AW-1:0] r;
        r = raddr;
        return r[k*AW +: AW];
    endfunction

    function automatic logic [XLEN-1:0] exp_rdata(input int k);
        logic [AW-1:0] a;
        a = port_addr(k);
        if (!m_ready || a == 0) return '0;
        if (we && waddr == a) return wdata;
        return m_regs[a];
    endfunction

    function automatic logic exp_rbusy(input int k);
        logic [AW-1:0] a;
        a = port_addr(k);
        return m_ready && m_busy[a] && !(we && waddr == a);
    endfunction

    task automatic check_outputs();
        check("init_done", init_done, m_ready);
        for (int k = 0; k < NRD; k++) begin
            check($sformatf("rdata%0d", k), rdata[k*XLEN +: XLEN], exp_rdata(k));
            check($sformatf("rbusy%0d", k), rbusy[k], exp_rbusy(k));
        end
        check("rsv_waw", rsv_waw, m_ready && rsv_valid && m_busy[rsv_addr]);
    endtask

    // Advance the model by one rising edge using the inputs held across it.
    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else if (!m_ready) begin
            m_edges++;
            if (m_edges == NREGS) begin
                m_ready = 1;
                for (int i = 0; i < NREGS; i++) m_regs[i] = XLEN'(i);
            end
        end else begin
            if (we && waddr != 0) m_regs[waddr] = wdata;
            if (flush) for (int i = 0; i < NREGS; i++) m_busy[i] = 0;
            if (we) m_busy[waddr] = 0;
            if (rsv_valid && rsv_addr != 0) m_busy[rsv_addr] = 1;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        $display("cyc %0d rst_n=%0b we=%0b wa=%0d wd=%h ra=%h rd=%h rb=%b rsv=%0b/%0d waw=%0b fl=%0b rdy=%0b",
                 cyc, rst_n, we, waddr, wdata, raddr, rdata, rbusy, rsv_valid, rsv_addr,
                 rsv_waw, flush, init_done);
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (!init_done && n < 64) begin
            cycle();
            n++;
        end
        check(tag, n, NREGS);
    endtask

    task automatic set_raddr(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        raddr = {a1, a0};
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_done"}, init_done, 1'b0);
        check({tag, "_rdata"}, rdata, '0);
        check({tag, "_rbusy"}, rbusy, '0);
        check({tag, "_waw"}, rsv_waw, 1'b0);
    endtask

    initial begin
        model_reset();
        // Writes and reservations presented during the sweep must be ignored.
        we = 1; waddr = 5; wdata = 32'hDEAD;
        rsv_valid = 1; rsv_addr = 3;
        set_raddr(5, 31);
        #1;
        check_reset_outputs("reset");
        cycle();
        cycle();
        rst_n = 1;
        wait_init("init_latency");
        we = 0; rsv_valid = 0;
        #1;
        check("init_r5", rdata[0 +: XLEN], 32'h5);
        check("init_r31", rdata[XLEN +: XLEN], 32'h1F);
        check("init_busy3", rbusy, 2'b00);
        set_raddr(0, 17);
        #1;
        check("init_r0", rdata[0 +: XLEN], 32'h0);
        cycle();

        // Bypass and write persistence
        we = 1; waddr = 7; wdata = 32'hCAFEBABE; set_raddr(7, 7);
        #1;
        check("bypass", rdata[0 +: XLEN], 32'hCAFEBABE);
        cycle();
        we = 0;
        #1;
        check("stored", rdata[XLEN +: XLEN], 32'hCAFEBABE);
        cycle();

        // Entry zero is never written or reserved
        we = 1; waddr = 0; wdata = 32'hFFFFFFFF; rsv_valid = 1; rsv_addr = 0; set_raddr(0, 0);
        #1;
        check("zero_same", rdata[0 +: XLEN], 32'h0);
        cycle();
        we = 0; rsv_valid = 0;
        #1;
        check("zero_after", rdata[0 +: XLEN], 32'h0);
        check("zero_busy", rbusy[0], 1'b0);
        cycle();

        // Reservation, WAW, reserve racing writeback, lone writeback
        rsv_valid = 1; rsv_addr = 9; set_raddr(9, 1);
        cycle();
        #1;
        check("rsv_busy", rbusy[0], 1'b1);
        check("rsv_waw9", rsv_waw, 1'b1);
        cycle();
        we = 1; waddr = 9; wdata = 32'h1234;
        cycle();
        we = 0; rsv_valid = 0;
        #1;
        check("rsv_wins", rbusy[0], 1'b1);
        cycle();
        we = 1; waddr = 9; wdata = 32'h5678;
        cycle();
        we = 0;
        #1;
        check("wb_clears", rbusy[0], 1'b0);
        cycle();

        // Flush racing a reservation keeps only the new bit
        rsv_valid = 1;
        rsv_addr = 3; cycle();
        rsv_addr = 4; cycle();
        rsv_addr = 6; cycle();
        flush = 1; rsv_addr = 4; cycle();
        flush = 0; rsv_valid = 0;
        set_raddr(3, 4);
        #1;
        check("flush_34", rbusy, 2'b10);
        set_raddr(6, 9);
        #1;
        check("flush_69", rbusy, 2'b00);
        cycle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            we        = 1'($urandom_range(0, 1));
            waddr     = AW'($urandom_range(0, NREGS - 1));
            wdata     = $urandom;
            rsv_valid = 1'($urandom_range(0, 1));
            rsv_addr  = AW'($urandom_range(0, NREGS - 1));
            flush     = ($urandom_range(0, 15) == 0);
            for (int k = 0; k < NRD; k++) begin
                if ($urandom_range(0, 3) == 0) raddr[k*AW +: AW] = waddr;
                else raddr[k*AW +: AW] = AW'($urandom_range(0, NREGS - 1));
            end
            cycle();
        end
        we = 0; flush = 0; rsv_valid = 0;

        // Reset mid-operation with busy bits set
        rsv_valid = 1; rsv_addr = 12; cycle();
        rsv_valid = 0; set_raddr(12, 7);
        #1;
        check("pre_rst_busy", rbusy[0], 1'b1);
        #2;
        rst_n = 0;
        model_reset();
        #1;
        check_reset_outputs("rst_op");
        cycle();
        rst_n = 1;
        wait_init("init_latency_op");
        #1;
        check("post_rst_busy", rbusy[0], 1'b0);

        // Reset mid-sweep restarts it
        rst_n = 0;
        model_reset();
        cycle();
        rst_n = 1;
        for (int i = 0; i < 10; i++) cycle();
        rst_n = 0;
        model_reset();
        #1;
        check_reset_outputs("rst_sweep");
        cycle();
        rst_n = 1;
        wait_init("init_latency_sweep");
        set_raddr(20, 31);
        #1;
        check("sweep_r20", rdata[0 +: XLEN], 32'd20);
        cycle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised integer register file for the RV32 core: configurable word width, depth and read-port count, with one synchronous write port.
- Adds an issue-side scoreboard: one busy bit per register, set at reservation and cleared on writeback.
- Adds write-to-read bypass.
- After reset, a sequential init sweep loads every entry before the file reports ready.

Parameters:
- XLEN, 32, data word width in bits.
- NREGS, 32, number of registers (power of two, >= 2); AW = clog2(NREGS).
- NRD, 2, number of combinational read ports.
- ZERO_REG, 1, when 1 entry 0 is hardwired to zero: never written, never reserved, reads 0.
- INIT_IDX, 1, init sweep loads entry i with value i (zero-extended) when 1, with 0 when 0.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- init_done  output  1  high once the init sweep has completed.
- we  input  1  write enable.
- waddr  input  AW  write address.
- wdata  input  XLEN  write data.
- raddr  input  NRD*AW  packed read addresses; port k uses bits [k*AW +: AW].
- rdata  output  NRD*XLEN  packed read data; port k uses bits [k*XLEN +: XLEN].
- rbusy  output  NRD  per-port scoreboard status for raddr[k].
- rsv_valid  input  1  reserve the destination register at issue.
- rsv_addr  input  AW  register to reserve.
- rsv_waw  output  1  high when rsv_addr is already busy (WAW hazard).
- flush  input  1  synchronous clear of all busy bits.

Behaviour:
- Reset (async assert, rst_n=0):
  - state=INIT, sweep counter=0, all busy bits=0, init_done=0.
  - rdata=0, rbusy=0, rsv_waw=0.
  - Storage contents are undefined until the sweep completes.
- FSM state INIT:
  - Each cycle writes the init value to regs[cnt], then cnt++.
  - When cnt==NREGS-1 is written, the next state is READY; init_done rises exactly NREGS cycles after rst_n deasserts.
  - During INIT: we, rsv_valid and flush are ignored; rdata, rbusy and rsv_waw are forced to 0.
- FSM state READY: stays there until the next reset. Reset mid-sweep restarts the sweep at 0.
- Write:
  - On the rising edge with we=1, regs[waddr] <= wdata.
  - Suppressed when ZERO_REG=1 and waddr==0.
  - The same edge clears busy[waddr].
- Read (combinational, zero latency):
  - rdata[k] = 0 if ZERO_REG and raddr[k]==0.
  - Otherwise rdata[k] = wdata if we && waddr==raddr[k] (bypass).
  - Otherwise rdata[k] = regs[raddr[k]].
  - Multiple ports may read the same address.
- rbusy[k] = busy[raddr[k]] & ~(we && waddr==raddr[k]). A same-cycle writeback hides the busy bit because the value is bypassed.
- Reservation:
  - rsv_valid=1 sets busy[rsv_addr] on the edge; ignored for entry 0 when ZERO_REG=1.
  - rsv_waw = rsv_valid & busy[rsv_addr], combinational. This is informational only; the reservation still proceeds.
- Simultaneous events, same edge:
  - rsv and write to the same address: the busy bit ends set (the new producer wins); the data write still occurs.
  - flush with rsv_valid: busy ends all-zero except the bit being reserved.
  - flush with we: the data write occurs; all busy bits end 0.
- Width rules:
  - Addresses are AW bits and never wrap.
  - INIT_IDX values are index truncated/zero-extended to XLEN.

Test Plan:
- Release rst_n, hold we=1 waddr=5 wdata=0xDEAD during the sweep: init_done rises exactly 32 cycles later. Then raddr0=5 -> 0x5 (write ignored); raddr1=31 -> 0x1F; raddr=0 -> 0.
- READY, we=1 waddr=7 wdata=0xCAFEBABE with raddr0=7 in the same cycle: rdata0=0xCAFEBABE combinationally; next cycle, with we=0, still 0xCAFEBABE.
- we=1 waddr=0 wdata=0xFFFFFFFF, ZERO_REG=1: raddr0=0 reads 0 in that cycle and after; rsv_addr=0 never sets busy.
- rsv_valid addr=9: next cycle rbusy=1 for raddr=9 and a second rsv on 9 gives rsv_waw=1. we waddr=9 plus rsv 9 on the same edge: busy stays 1. A later lone write clears it to 0.
- Reserve 3, 4, 6, then flush with rsv_valid addr=4 on the same edge: only busy[4]=1 afterwards.
- Assert rst_n=0 for one cycle mid-sweep (cycle 10) and mid-operation with busy bits set: outputs go 0 immediately, busy is cleared, and init_done rises 32 cycles after release.
